decode_onehot_scan: RTL and testbench
=====================================

Name: decode_onehot_scan

Overview:
- Parametrised, registered binary-to-one-hot decoder. Successor to the fixed 2-to-4 combinational decoder.
- Two modes:
  - direct: decodes an input code.
  - scan: walks a one-hot through all outputs at a prescaled rate. Used for multiplexed LED and 7-seg digit select.
- Adds out-of-range detection for output counts that are not a power of two.

Parameters:
- CODE_W, 2, code width in bits; must be >= 1.
- N_OUT, 4, number of one-hot outputs; legal range 2 ≤ N_OUT ≤ 2**CODE_W.
- PRESCALE, 4, enabled clock cycles per scan step; must be >= 1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  global enable; low freezes all state.
- mode  in  1  0 = direct, 1 = scan.
- code_valid  in  1  qualifies code in direct mode.
- code  in  CODE_W  binary code to decode.
- data  out  N_OUT  registered one-hot output.
- data_valid  out  1  one-cycle pulse: data was updated on this edge.
- scan_idx  out  CODE_W  index that the next scan step will drive.
- err  out  1  last accepted direct code was >= N_OUT.

Behaviour:
- Reset (rst=1 at an edge; overrides everything, including mid-scan):
  - data=0, data_valid=0, err=0, scan_idx=0, prescaler=0, mode_q=0.
- mode_q register:
  - Holds mode from the previous cycle.
  - Mode change: mode != mode_q at an edge.
- Mode change (has priority over normal operation that cycle):
  - data<=0, data_valid<=0, err<=0, scan_idx<=0, prescaler<=0.
  - Happens regardless of en.
- en=0 (and no mode change):
  - data, err, scan_idx and prescaler hold.
  - data_valid<=0.
- Direct mode (mode=mode_q=0, en=1):
  - code_valid=1 and code < N_OUT: data<=1<<code, err<=0, data_valid<=1. Latency 1 cycle.
  - code_valid=1 and code >= N_OUT: data<=0, err<=1, data_valid<=1.
  - code_valid=0: data and err hold, data_valid<=0.
  - err is sticky until the next accepted code. scan_idx and prescaler hold.
- Scan mode (mode=mode_q=1, en=1):
  - Prescaler counts 0..PRESCALE-1 and wraps.
  - Step condition: prescaler==PRESCALE-1.
  - On a step: data<=1<<scan_idx; scan_idx<=(scan_idx==N_OUT-1) ? 0 : scan_idx+1; data_valid<=1.
  - Not a step: data holds, data_valid<=0.
  - code and code_valid are ignored; err holds at 0.
  - Timing after the mode change clears the counters: the first step, one-hot bit 0, is the PRESCALE-th enabled cycle.
  - PRESCALE=1: a step occurs every enabled cycle.
- Width rules:
  - Comparisons use CODE_W-bit unsigned values.
  - When N_OUT == 2**CODE_W, err is never set; no explicit wrap logic is needed because natural overflow equals the wrap.
  - Prescaler width is $clog2(PRESCALE+1).
- data is always one-hot or all-zero; never more than one bit set.

Optional Feature:
- Macro: DECODE_ACTIVE_LOW_EN.
- Defined:
  - data is driven bitwise inverted (active-low selects for common-anode displays).
  - Reset and mode-change value of data is all ones.
  - data_valid, err and scan_idx are unaffected; the inversion is applied only at the data output register.
- Undefined: active-high, as described above.

Decomposition:
- Package decode_pkg:
  - Mode constants MODE_DIRECT=1'b0 and MODE_SCAN=1'b1.
  - Pure function onehot(idx, width) returning the shifted one-hot value, shared with future decoders.
- Sub-module tick_gen (parameter PRESCALE; ports clk, rst, clr, en, tick):
  - Owns the prescaler.
  - clr is driven by reset-or-mode-change; tick is the step condition.
- Everything else lives in the top.

Test Plan:
- Reset, then direct mode, CODE_W=2, N_OUT=4:
  - Codes 0,1,2,3 on consecutive cycles with code_valid=1.
  - data = 0001, 0010, 0100, 1000, each one cycle later; data_valid high for 4 cycles.
- Out-of-range, CODE_W=3, N_OUT=5:
  - code=6 valid: data=00000, err=1, data_valid=1.
  - code_valid low for 3 cycles: err stays 1.
  - code=4: data=10000, err=0.
- Scan with PRESCALE=3, N_OUT=4:
  - data_valid pulses every 3rd cycle.
  - data sequence 0001, 0010, 0100, 1000, 0001; scan_idx wraps 3 to 0.
- en gating mid-scan:
  - Drop en for 5 cycles just before a step: no data change, no pulse, prescaler frozen.
  - Step occurs on the first enabled cycle after en returns.
- Mode switch and mid-scan reset:
  - Switch scan to direct while data=0100: next cycle data=0000, scan_idx=0.
  - Assert rst mid-scan: all outputs zero on the following cycle.
- DECODE_ACTIVE_LOW_EN build:
  - After reset data=1111.
  - Direct code=2 gives data=1011; err and data_valid match the active-high build.

Source files
------------

// File: rtl/decode_pkg.sv
// decode_pkg: mode encoding and one-hot helper shared by the decoder family.
package decode_pkg;
  typedef enum logic {MODE_DIRECT = 1'b0, MODE_SCAN = 1'b1} mode_e;
  localparam int ONEHOT_MAX = 64;
  function automatic logic [ONEHOT_MAX-1:0] onehot(input int unsigned idx, input int unsigned width);
    return (idx < width) ? ONEHOT_MAX'(1) << idx : '0;
  endfunction
endpackage

// File: rtl/decode_onehot_scan_if.sv
// decode_onehot_scan_if: control inputs and registered outputs of the one-hot decoder.
interface decode_onehot_scan_if #(parameter int CODE_W = 2, parameter int N_OUT = 4);
  logic en;
  logic mode;
  logic code_valid;
  logic [CODE_W-1:0] code;
  logic [N_OUT-1:0] data;
  logic data_valid;
  logic [CODE_W-1:0] scan_idx;
  logic err;
  modport master(output en, mode, code_valid, code, input data, data_valid, scan_idx, err);
  modport slave(input en, mode, code_valid, code, output data, data_valid, scan_idx, err);
endinterface

// File: rtl/tick_gen.sv
// tick_gen: prescaler counting enabled cycles; tick marks the last cycle of each period.
module tick_gen #(parameter int PRESCALE = 4) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int PW = $clog2(PRESCALE + 1);
  logic [PW-1:0] cnt;
  assign tick = en && cnt == PW'(PRESCALE - 1);
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/decode_onehot_scan.sv
// decode_onehot_scan: registered binary-to-one-hot decoder with direct and scan modes.
// Define DECODE_ACTIVE_LOW_EN for inverted (active-low) data selects.
module decode_onehot_scan
  import decode_pkg::*;
#(
  parameter int CODE_W   = 2,
  parameter int N_OUT    = 4,
  parameter int PRESCALE = 4
) (
  input logic clk,
  input logic rst,
  decode_onehot_scan_if.slave bus
);
`ifdef DECODE_ACTIVE_LOW_EN
  localparam logic [N_OUT-1:0] POL = '1;
`else
  localparam logic [N_OUT-1:0] POL = '0;
`endif
  logic mode_q, mode_chg, tick, code_ok;
  logic [ONEHOT_MAX-1:0] code_oh, scan_oh;
  logic [N_OUT-1:0] data_q;
  logic [CODE_W-1:0] idx_q;
  logic dv_q, err_q;
  assign mode_chg = bus.mode != mode_q;
  assign code_ok = 32'(bus.code) < N_OUT;
  assign code_oh = onehot(32'(bus.code), N_OUT);
  assign scan_oh = onehot(32'(idx_q), N_OUT);
  // prescaler only advances while settled in scan mode
  tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk(clk),
    .rst(rst),
    .clr(rst | mode_chg),
    .en(bus.en & bus.mode & mode_q),
    .tick(tick)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= POL;
      dv_q   <= 1'b0;
      err_q  <= 1'b0;
      idx_q  <= '0;
      mode_q <= MODE_DIRECT;
    end else begin
      mode_q <= bus.mode;
      if (mode_chg) begin
        data_q <= POL;
        dv_q   <= 1'b0;
        err_q  <= 1'b0;
        idx_q  <= '0;
      end else if (!bus.en) begin
        dv_q <= 1'b0;
      end else if (mode_q == MODE_DIRECT) begin
        dv_q <= bus.code_valid;
        if (bus.code_valid) begin
          data_q <= POL ^ (code_ok ? code_oh[N_OUT-1:0] : '0);
          err_q  <= !code_ok;
        end
      end else begin
        dv_q <= tick;
        if (tick) begin
          data_q <= POL ^ scan_oh[N_OUT-1:0];
          idx_q  <= idx_q == CODE_W'(N_OUT - 1) ? '0 : idx_q + 1'b1;
        end
      end
    end
  end
  assign bus.data       = data_q;
  assign bus.data_valid = dv_q;
  assign bus.err        = err_q;
  assign bus.scan_idx   = idx_q;
endmodule

// File: tb/tb_decode_onehot_scan.sv
// tb_decode_onehot_scan: scoreboard bench for two decoder configurations.
module tb_decode_onehot_scan;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  decode_onehot_scan_if #(.CODE_W(2), .N_OUT(4)) a ();
  decode_onehot_scan_if #(.CODE_W(3), .N_OUT(5)) b ();
  decode_onehot_scan #(.CODE_W(2), .N_OUT(4), .PRESCALE(3)) dut_a (.clk(clk), .rst(rst), .bus(a.slave));
  decode_onehot_scan #(.CODE_W(3), .N_OUT(5), .PRESCALE(1)) dut_b (.clk(clk), .rst(rst), .bus(b.slave));
`ifdef DECODE_ACTIVE_LOW_EN
  localparam bit AL = 1'b1;
`else
  localparam bit AL = 1'b0;
`endif
  typedef struct {
    string name;
    logic [12:0] v;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int errors = 0;
  int checks = 0;
  function automatic logic [12:0] ea(input int d, input int dv, input int er, input int i);
    logic [7:0] x = 8'(d);
    return {AL ? x ^ 8'h0F : x, 1'(dv), 1'(er), 3'(i)};
  endfunction
  function automatic logic [12:0] eb(input int d, input int dv, input int er, input int i);
    logic [7:0] x = 8'(d);
    return {AL ? x ^ 8'h1F : x, 1'(dv), 1'(er), 3'(i)};
  endfunction
  function automatic logic [12:0] obs_a();
    return {4'b0, a.data, a.data_valid, a.err, 1'b0, a.scan_idx};
  endfunction
  function automatic logic [12:0] obs_b();
    return {3'b0, b.data, b.data_valid, b.err, b.scan_idx};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drv_a(input int en, input int mode, input int cv, input int code);
    a.en = 1'(en); a.mode = 1'(mode); a.code_valid = 1'(cv); a.code = 2'(code);
  endtask
  task automatic drv_b(input int en, input int mode, input int cv, input int code);
    b.en = 1'(en); b.mode = 1'(mode); b.code_valid = 1'(cv); b.code = 3'(code);
  endtask
  task automatic test_reset();
    rst = 1'b1;
    drv_a(0, 0, 0, 0);
    drv_b(0, 0, 0, 0);
    sb.push_back('{"reset_a", ea(0, 0, 0, 0)});
    sb.push_back('{"reset_b", eb(0, 0, 0, 0)});
    step();
    rst = 1'b0;
    e = sb.pop_front(); checks++;
    if (obs_a() !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs_a(), e.v); end
    e = sb.pop_front(); checks++;
    if (obs_b() !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs_b(), e.v); end
  endtask
  task automatic test_direct();
    for (int i = 0; i < 5; i++) begin
      drv_a(1, 0, i < 4, i < 4 ? i : 0);
      sb.push_back('{$sformatf("direct_%0d", i), i < 4 ? ea(1 << i, 1, 0, 0) : ea(8, 0, 0, 0)});
      step();
      e = sb.pop_front(); checks++;
      if (obs_a() !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs_a(), e.v); end
    end
  endtask
  task automatic test_out_of_range();
    int codes[7] = '{6, 0, 0, 0, 4, 5, 7};
    int cvs[7]   = '{1, 0, 0, 0, 1, 1, 1};
    int dat[7]   = '{0, 0, 0, 0, 16, 0, 0};
    int ers[7]   = '{1, 1, 1, 1, 0, 1, 1};
    drv_a(0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      drv_b(1, 0, cvs[i], codes[i]);
      sb.push_back('{$sformatf("range_%0d", i), eb(dat[i], cvs[i], ers[i], 0)});
      step();
      e = sb.pop_front(); checks++;
      if (obs_b() !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs_b(), e.v); end
    end
    drv_b(0, 0, 0, 0);
  endtask
  task automatic test_scan();
    for (int k = 0; k < 16; k++) begin
      int s = k / 3;
      drv_a(1, 1, 1, k);
      sb.push_back('{$sformatf("scan_%0d", k), k == 0 ? ea(0, 0, 0, 0) :
                     ea(s == 0 ? 0 : 1 << ((s - 1) % 4), k % 3 == 0, 0, s % 4)});
      step();
      e = sb.pop_front(); checks++;
      if (obs_a() !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs_a(), e.v); end
    end
  endtask
  task automatic test_en_gating();
    for (int k = 0; k < 8; k++) begin
      drv_a(k < 2 || k == 7, 1, 0, 0);
      sb.push_back('{$sformatf("gate_%0d", k), k == 7 ? ea(2, 1, 0, 2) : ea(1, 0, 0, 1)});
      step();
      e = sb.pop_front(); checks++;
      if (obs_a() !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs_a(), e.v); end
    end
  endtask
  task automatic test_mode_switch();
    logic [12:0] ex[11];
    ex = '{ea(2, 0, 0, 2), ea(2, 0, 0, 2), ea(4, 1, 0, 3), ea(0, 0, 0, 0), ea(2, 1, 0, 0),
           ea(0, 0, 0, 0), ea(0, 0, 0, 0), ea(0, 0, 0, 0), ea(1, 1, 0, 1), ea(1, 0, 0, 1), ea(0, 0, 0, 0)};
    for (int k = 0; k < 11; k++) begin
      rst = k == 10;
      if (k == 3) drv_a(1, 0, 0, 0);
      else if (k == 4) drv_a(1, 0, 1, 1);
      else drv_a(1, 1, 0, 0);
      sb.push_back('{$sformatf("switch_%0d", k), ex[k]});
      step();
      e = sb.pop_front(); checks++;
      if (obs_a() !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs_a(), e.v); end
    end
    rst = 1'b0;
    drv_a(0, 0, 0, 0);
  endtask
  task automatic test_scan_b();
    for (int k = 0; k < 7; k++) begin
      drv_b(1, 1, 1, 6);
      sb.push_back('{$sformatf("scan_b_%0d", k), k == 0 ? eb(0, 0, 0, 0) : eb(1 << ((k - 1) % 5), 1, 0, k % 5)});
      step();
      e = sb.pop_front(); checks++;
      if (obs_b() !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.name, obs_b(), e.v); end
    end
  endtask
  initial begin
    #2;
    test_reset();
    test_direct();
    test_out_of_range();
    test_scan();
    test_en_gating();
    test_mode_switch();
    test_scan_b();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
